morse_symbol_source: RTL and testbench

//  Upstream stage of the Morse display path: letter store, symbol shift register
//  and half-second pulse counter for the Lab 5 Part 4 letter display.

---
 rtl/morse_symbol_source.sv | 130 +++++++++++++
 tb/tb_morse_symbol_source.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_source.sv
// rtl/morse_symbol_source.sv - Morse letter store, symbol shifter and half-second counter
//
// Purpose:
//   Upstream stage of the Morse letter display. A switch-selected letter (A..H)
//   is synchronised into the clock domain, then loaded on ld_in into a size and
//   pattern register. The current symbol (0=dot, 1=dash) is pattern bit 0, and
//   en_reg_in steps to the next symbol. A prescaler produces a one-cycle tick
//   every TICK_DIV enabled cycles and advances a free-running 0..3 count that
//   the display logic compares against 1 (dot) or 3 (dash).
//
// Ports:
//   clk             in   1  system clock
//   reset_n         in   1  synchronous active-low reset
//   letter_sel      in   3  raw switch value, 0=A .. 7=H (asynchronous)
//   ld_in           in   1  load synced letter into size/pattern
//   en_reg_in       in   1  shift to next symbol
//   en_count_in     in   1  enable prescaler / count2 advance
//   reset_count_in  in   1  active-low clear of prescaler and count2
//   size_out        out  3  symbols in letter minus one
//   sym_out         out  1  current symbol: 0=dot, 1=dash
//   count2_out      out  2  half-second count, wraps 3->0
//   half_sec_out    out  1  one-cycle tick at each prescaler wrap

module morse_symbol_source #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DIV_W    = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] letter_sel,
    input  logic       ld_in,
    input  logic       en_reg_in,
    input  logic       en_count_in,
    input  logic       reset_count_in,
    output logic [2:0] size_out,
    output logic       sym_out,
    output logic [1:0] count2_out,
    output logic       half_sec_out
);

    localparam logic [DIV_W-1:0] LP_PRESC_LAST = DIV_W'(TICK_DIV - 1);

    // Two-flop synchronizer for the switch value
    logic [2:0]       r_sel_s1;
    logic [2:0]       r_sel_s2;

    logic [2:0]       r_size;
    logic [3:0]       r_pattern;

    logic [DIV_W-1:0] r_presc;
    logic [1:0]       r_count2;
    logic             r_half_sec;

    logic [2:0]       w_ld_size;
    logic [3:0]       w_ld_pattern;
    logic             w_presc_wrap;

    // Letter table: pattern LSB is the first symbol, unused upper bits are 0
    always_comb begin
        w_ld_size    = 3'd0;
        w_ld_pattern = 4'b0000;
        case (r_sel_s2)
            3'd0: begin w_ld_size = 3'd1; w_ld_pattern = 4'b0010; end // A .-
            3'd1: begin w_ld_size = 3'd3; w_ld_pattern = 4'b0001; end // B -...
            3'd2: begin w_ld_size = 3'd3; w_ld_pattern = 4'b0101; end // C -.-.
            3'd3: begin w_ld_size = 3'd2; w_ld_pattern = 4'b0001; end // D -..
            3'd4: begin w_ld_size = 3'd0; w_ld_pattern = 4'b0000; end // E .
            3'd5: begin w_ld_size = 3'd3; w_ld_pattern = 4'b0100; end // F ..-.
            3'd6: begin w_ld_size = 3'd2; w_ld_pattern = 4'b0011; end // G --.
            3'd7: begin w_ld_size = 3'd3; w_ld_pattern = 4'b0000; end // H ....
            default: begin w_ld_size = 3'd0; w_ld_pattern = 4'b0000; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sel_s1 <= 3'd0;
            r_sel_s2 <= 3'd0;
        end else begin
            r_sel_s1 <= letter_sel;
            r_sel_s2 <= r_sel_s1;
        end
    end

    // Letter register: load beats shift; shifting past the end feeds zeros (dots)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_size    <= 3'd0;
            r_pattern <= 4'b0000;
        end else if (ld_in) begin
            r_size    <= w_ld_size;
            r_pattern <= w_ld_pattern;
        end else if (en_reg_in) begin
            r_pattern <= {1'b0, r_pattern[3:1]};
        end
    end

    assign w_presc_wrap = (r_presc == LP_PRESC_LAST);

    // Prescaler restarts at 0 on every clear, so the first tick after a clear
    // comes a full TICK_DIV enabled cycles later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc    <= '0;
            r_count2   <= 2'd0;
            r_half_sec <= 1'b0;
        end else if (!reset_count_in || ld_in) begin
            r_presc    <= '0;
            r_count2   <= 2'd0;
            r_half_sec <= 1'b0;
        end else if (en_count_in) begin
            if (w_presc_wrap) begin
                r_presc    <= '0;
                r_count2   <= r_count2 + 2'd1;
                r_half_sec <= 1'b1;
            end else begin
                r_presc    <= r_presc + 1'b1;
                r_half_sec <= 1'b0;
            end
        end else begin
            r_half_sec <= 1'b0;
        end
    end

    assign size_out     = r_size;
    assign sym_out      = r_pattern[0];
    assign count2_out   = r_count2;
    assign half_sec_out = r_half_sec;

endmodule

// File: tb/tb_morse_symbol_source.sv
// tb/tb_morse_symbol_source.sv - self-checking bench for morse_symbol_source
module tb_morse_symbol_source;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] letter_sel = 3'd0;
    logic       ld_in = 1'b0;
    logic       en_reg_in = 1'b0;
    logic       en_count_in = 1'b0;
    logic       reset_count_in = 1'b1;
    logic [2:0] size_out;
    logic       sym_out;
    logic [1:0] count2_out;
    logic       half_sec_out;

    int n_checks = 0;
    int n_errors = 0;

    morse_symbol_source #(.TICK_DIV(TD), .DIV_W(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .letter_sel     (letter_sel),
        .ld_in          (ld_in),
        .en_reg_in      (en_reg_in),
        .en_count_in    (en_count_in),
        .reset_count_in (reset_count_in),
        .size_out       (size_out),
        .sym_out        (sym_out),
        .count2_out     (count2_out),
        .half_sec_out   (half_sec_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    string letters[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    int    sync_q[$] = '{0, 0};   // switch values seen at the last two edges
    string m_str = "";
    int    m_size = 0;
    int    m_idx = 0;
    int    m_adv = 0;             // enabled advances since the last clear
    int    m_tick = 0;
    bit    m_valid = 1'b0;

    function automatic int model_sym();
        if (m_idx < m_str.len() && m_str.getc(m_idx) == "-") return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        int used;
        used = sync_q[0];
        if (!reset_n) begin
            sync_q = '{0, 0};
            m_str = ""; m_size = 0; m_idx = 0;
            m_adv = 0; m_tick = 0;
        end else begin
            void'(sync_q.pop_front());
            sync_q.push_back(int'(letter_sel));
            if (ld_in) begin
                m_str  = letters[used];
                m_size = m_str.len() - 1;
                m_idx  = 0;
            end else if (en_reg_in && m_idx < 8) begin
                m_idx++;
            end
            if (!reset_count_in || ld_in) begin
                m_adv = 0; m_tick = 0;
            end else if (en_count_in) begin
                m_adv++;
                m_tick = (m_adv % TD == 0) ? 1 : 0;
            end else begin
                m_tick = 0;
            end
        end
        m_valid = 1'b1;
    end

    // Compare process: every cycle, on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model size_out",   int'(size_out),     m_size);
            check("model sym_out",    int'(sym_out),      model_sym());
            check("model count2_out", int'(count2_out),   (m_adv / TD) % 4);
            check("model half_sec",   int'(half_sec_out), m_tick);
        end
    end

    // ---------------- stimulus ----------------
    // Drive inputs, let one rising edge pass, return just after the next falling edge
    task automatic step(input bit rn, input bit ld, input bit er, input bit ec, input bit rc);
        reset_n = rn; ld_in = ld; en_reg_in = er; en_count_in = ec; reset_count_in = rc;
        @(negedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1);
    endtask

    initial begin
        int exp_c2[4] = '{1, 2, 3, 0};
        bit found;

        repeat (2) @(negedge clk);
        #2;

        // 1: reset with all state nonzero
        letter_sel = 3'd2;
        idle(3);
        step(1, 1, 0, 0, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1, 0, 0, 1, 1);
            if (half_sec_out) found = 1'b1;
        end
        check("t1 tick reached", int'(found), 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);   // count2 = 1, sym = 1, size = 3
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (half_sec_out) found = 1'b1;
            else step(1, 0, 0, 1, 1);
        end
        check("t1 second tick", int'(found), 1);
        step(0, 0, 0, 1, 1);
        check("t1 size", int'(size_out), 0);
        check("t1 sym", int'(sym_out), 0);
        check("t1 count2", int'(count2_out), 0);
        check("t1 half", int'(half_sec_out), 0);

        // 2: letter A
        letter_sel = 3'd0;
        idle(3);
        step(1, 1, 0, 0, 1);
        check("t2 size", int'(size_out), 1);
        check("t2 sym0", int'(sym_out), 0);
        step(1, 0, 1, 0, 1);
        check("t2 sym1", int'(sym_out), 1);
        step(1, 0, 1, 0, 1);
        check("t2 sym2", int'(sym_out), 0);

        // 3: letter C, shift through and past the end
        letter_sel = 3'd2;
        idle(3);
        step(1, 1, 0, 0, 1);
        check("t3 size", int'(size_out), 3);
        check("t3 sym0", int'(sym_out), 1);
        step(1, 0, 1, 0, 1);
        check("t3 sym1", int'(sym_out), 0);
        step(1, 0, 1, 0, 1);
        check("t3 sym2", int'(sym_out), 1);
        step(1, 0, 1, 0, 1);
        check("t3 sym3", int'(sym_out), 0);
        step(1, 0, 1, 0, 1);
        check("t3 sym past end", int'(sym_out), 0);
        check("t3 size held", int'(size_out), 3);

        // 4: 17 enabled cycles after a clear
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            step(1, 0, 0, 1, 1);
            if (k % 4 == 0) begin
                check("t4 tick", int'(half_sec_out), 1);
                check("t4 count2", int'(count2_out), exp_c2[k / 4 - 1]);
            end else if (k == 5 || k == 17) begin
                check("t4 no tick", int'(half_sec_out), 0);
            end
        end

        // 5: clear on the cycle a tick is due
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);
        check("t5 count2 cleared", int'(count2_out), 0);
        check("t5 tick suppressed", int'(half_sec_out), 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 1);
        check("t5 no early tick", int'(half_sec_out), 0);
        step(1, 0, 0, 1, 1);
        check("t5 tick after release", int'(half_sec_out), 1);
        check("t5 count2 after release", int'(count2_out), 1);

        // 6: load and shift on the same edge, load wins
        letter_sel = 3'd1;
        idle(3);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 1);
        step(1, 1, 1, 1, 1);
        check("t6 sym", int'(sym_out), 1);
        check("t6 size", int'(size_out), 3);
        check("t6 count2", int'(count2_out), 0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) letter_sel = 3'($urandom_range(0, 7));
            step($urandom_range(0, 63) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 23) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
